pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage SimpleRISC pipeline (IF/OF/EX/DM/WB).
//  Drives the stall inputs of the PC and of every inter-stage register (IFOF, OFEX, EXDM, DMWB).
//  Three hazard sources, in priority order:
//    1. data-memory wait states, via a req/ack handshake FSM;
//    2. taken-branch flush;
//    3. load-use interlock.
//  Also gates writeback so that an instruction held in WB writes the register file only once.
// PARAMETERS
//  DM_TIMEOUT  16  max cycles in WAIT without dm_ack before abort (>=2)
//  CNT_W       32  width of stall performance counter (saturating)
//  REG_W       5   register-specifier width
// PORTS
//  clk             in   1      pipeline clock, all state on rising edge
//  rst_n           in   1      asynchronous active-low reset
//  mem_access_DM   in   1      instruction in DM stage is ld or st
//  dm_ack          in   1      data memory: access complete, read data valid this cycle
//  dm_req          out  1      data memory: access request (held until ack/timeout)
//  is_Ld_EX        in   1      instruction in EX stage is a load
//  rd_EX           in   REG_W  destination of EX-stage instruction
//  rs1_OF, rs2_OF  in   REG_W  source specifiers of OF-stage instruction
//  use_rs1_OF      in   1      OF instruction reads rs1
//  use_rs2_OF      in   1      OF instruction reads rs2
//  branch_taken_EX in   1      EX resolved a taken branch/jump
//  stall_PC        out  1      hold PC
//  stall_IFOF      out  1      hold IF/OF register
//  stall_OFEX      out  1      hold OF/EX register
//  stall_EXDM      out  1      hold EX/DM register
//  stall_DMWB      out  1      hold DM/WB register
//  flush_IFOF      out  1      load NOP into IF/OF
//  flush_OFEX      out  1      load NOP (bubble) into OF/EX
//  wb_suppress     out  1      block regfile write (WB instruction already written)
//  dm_err          out  1      sticky: a DM access timed out
//  err_clr         in   1      synchronous clear of dm_err
//  stall_cnt       out  CNT_W  cycles with stall_PC=1, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FSM->IDLE; wait counter=0; dm_err=0; stall_cnt=0; wb_suppress=0.
//   - With mem_access_DM=0, all stall/flush outputs and dm_req are 0.
//   - Reset mid-WAIT drops dm_req immediately.
//  Memory FSM (IDLE, WAIT); dm_req = mem_access_DM & (IDLE | WAIT), combinational.
//   IDLE, mem_access_DM & dm_ack : zero-wait access; no stall; stay IDLE.
//   IDLE, mem_access_DM & !ack   : mem_stall=1; ->WAIT; wcnt=1.
//   WAIT, !dm_ack & wcnt<DM_TIMEOUT-1 : mem_stall=1; wcnt++.
//   WAIT, dm_ack : mem_stall=0 (DMWB captures data this edge); ->IDLE.
//   WAIT, timeout (wcnt==DM_TIMEOUT-1 & !ack) : mem_stall=0; dm_err<=1; ->IDLE.
//     The instruction retires with undefined data.
//  mem_stall=1 : all five stalls=1; flush_*=0; branch and load-use evaluation deferred.
//  Branch (mem_stall=0, branch_taken_EX=1):
//   - flush_IFOF=flush_OFEX=1; PC loads target (no stall_PC).
//   - Load-use is suppressed in the same cycle, because the consumer is being flushed.
//  Load-use (mem_stall=0, no branch):
//   - Condition: is_Ld_EX & rd_EX matches rs1_OF (use_rs1_OF) or rs2_OF (use_rs2_OF).
//   - Action: stall_PC=stall_IFOF=1, flush_OFEX=1; EXDM/DMWB advance.
//   - Exactly one bubble; the load then sits in DM and forwarding covers the rest.
//  wb_suppress: register of stall_DMWB. It is 1 on every cycle after the first in which
//   the DM/WB register holds the same instruction.
//  err_clr and a timeout in the same cycle: the timeout wins, dm_err=1.
//  stall_cnt: +1 per cycle with stall_PC=1; holds at 2^CNT_W-1.
//  All stall/flush outputs are combinational from inputs and FSM state; no added latency.
// STRUCTURE
//  Shared package (pipe_pkg):
//   - REG_W;
//   - mem FSM state enum {MS_IDLE, MS_WAIT};
//   - NOP instruction constant used by the flushed registers.
//  One natural sub-module: dm_wait_fsm, containing the handshake FSM, the timeout counter
//   and dm_err; it outputs mem_stall and dm_req.
//  Top level holds priority logic, load-use compare, wb_suppress and stall_cnt.
// TESTING
//  1. ld in DM, dm_ack on 3rd cycle of request:
//     -> all stalls=1 for exactly 2 cycles, dm_req=1 for 3 cycles;
//        wb_suppress=1 on cycles 2-3 of the hold; stall_cnt=2.
//  2. ld r3 in EX, add r5,r3,r1 in OF:
//     -> one cycle stall_PC=stall_IFOF=flush_OFEX=1, stall_EXDM=0.
//     Repeat with use_rs1_OF=0 -> no stall.
//  3. branch_taken_EX=1 with a load-use match present:
//     -> flush_IFOF=flush_OFEX=1, stall_PC=0.
//  4. Branch in EX while DM in WAIT:
//     -> no flush until the ack cycle; flush asserted on the ack cycle.
//  5. DM_TIMEOUT=16, never ack:
//     -> stall for 15 cycles, release, dm_err=1 and stays 1; err_clr pulse -> 0.
//  6. rst_n low in cycle 2 of WAIT:
//     -> dm_req and stalls drop asynchronously; after release FSM=IDLE, stall_cnt=0.
//  7. Back-to-back ld/st with zero-wait ack:
//     -> no stalls, stall_cnt stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the SimpleRISC pipeline control slice.
//   REG_W       : register-specifier width
//   mem_state_e : data-memory handshake FSM states
//   NOP_INSN    : encoding loaded into IF/OF and OF/EX when they are flushed
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic {
    MS_IDLE,
    MS_WAIT
  } mem_state_e;

  // SimpleRISC nop: opcode 01101 in bits [31:27], all other fields zero
  localparam logic [31:0] NOP_INSN = 32'h6800_0000;

endpackage

// File: rtl/dm_wait_fsm.sv
// Data-memory req/ack handshake sequencer.
// Raises mem_stall while a DM-stage access waits for dm_ack, aborts the access after
// DM_TIMEOUT-1 unacknowledged wait cycles and records the abort in sticky dm_err.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mem_access_DM  DM-stage instruction is ld/st
//   dm_ack         memory completed the access this cycle
//   err_clr        synchronous clear of dm_err (a same-cycle timeout wins)
//   dm_req         access request to data memory
//   mem_stall      freeze the whole pipeline this cycle
//   dm_err         sticky timeout flag
module dm_wait_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned DM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_access_DM,
  input  logic dm_ack,
  input  logic err_clr,
  output logic dm_req,
  output logic mem_stall,
  output logic dm_err
);

  localparam int unsigned WCNT_W = (DM_TIMEOUT > 2) ? $clog2(DM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DM_TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              dm_err_q, dm_err_d;
  logic              stall_raw;
  logic              timeout;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    dm_err_d  = dm_err_q;
    stall_raw = 1'b0;
    timeout   = 1'b0;

    case (state_q)
      MS_IDLE: begin
        if (mem_access_DM && !dm_ack) begin
          stall_raw = 1'b1;
          state_d   = MS_WAIT;
          wcnt_d    = WCNT_W'(1);
        end
      end
      MS_WAIT: begin
        if (dm_ack) begin
          // DM/WB captures the read data on this edge
          state_d = MS_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          // Abort: the instruction retires with undefined data
          timeout = 1'b1;
          state_d = MS_IDLE;
          wcnt_d  = '0;
        end else begin
          stall_raw = 1'b1;
          wcnt_d    = wcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = MS_IDLE;
        wcnt_d  = '0;
      end
    endcase

    if (timeout) begin
      dm_err_d = 1'b1;
    end else if (err_clr) begin
      dm_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MS_IDLE;
      wcnt_q   <= '0;
      dm_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      dm_err_q <= dm_err_d;
    end
  end

  // Gated by rst_n so an access in flight is dropped the moment reset asserts
  assign dm_req    = rst_n & mem_access_DM & ((state_q == MS_IDLE) | (state_q == MS_WAIT));
  assign mem_stall = rst_n & stall_raw;
  assign dm_err    = dm_err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage SimpleRISC pipeline (IF/OF/EX/DM/WB).
// Priority: data-memory wait states > taken-branch flush > load-use interlock.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_access_DM, dm_ack      DM-stage access and memory completion
//   dm_req                     memory request (held until ack or timeout)
//   is_Ld_EX, rd_EX            EX-stage load and its destination
//   rs1_OF, rs2_OF             OF-stage source specifiers
//   use_rs1_OF, use_rs2_OF     OF-stage source-use flags
//   branch_taken_EX            EX resolved a taken branch/jump
//   stall_*                    hold PC / inter-stage registers
//   flush_IFOF, flush_OFEX     load NOP into IF/OF, OF/EX
//   wb_suppress                block regfile write for an instruction held in WB
//   dm_err, err_clr            sticky DM timeout flag and its clear
//   stall_cnt                  saturating count of cycles with stall_PC=1
module pipe_hazard_ctrl #(
  parameter int unsigned DM_TIMEOUT = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned REG_W      = pipe_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_access_DM,
  input  logic             dm_ack,
  output logic             dm_req,
  input  logic             is_Ld_EX,
  input  logic [REG_W-1:0] rd_EX,
  input  logic [REG_W-1:0] rs1_OF,
  input  logic [REG_W-1:0] rs2_OF,
  input  logic             use_rs1_OF,
  input  logic             use_rs2_OF,
  input  logic             branch_taken_EX,
  output logic             stall_PC,
  output logic             stall_IFOF,
  output logic             stall_OFEX,
  output logic             stall_EXDM,
  output logic             stall_DMWB,
  output logic             flush_IFOF,
  output logic             flush_OFEX,
  output logic             wb_suppress,
  output logic             dm_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             mem_stall;
  logic             load_use;
  logic             wb_suppress_q, wb_suppress_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  dm_wait_fsm #(
    .DM_TIMEOUT(DM_TIMEOUT)
  ) u_dm_wait_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_access_DM(mem_access_DM),
    .dm_ack       (dm_ack),
    .err_clr      (err_clr),
    .dm_req       (dm_req),
    .mem_stall    (mem_stall),
    .dm_err       (dm_err)
  );

  assign load_use = is_Ld_EX & ((use_rs1_OF & (rs1_OF == rd_EX)) |
                                (use_rs2_OF & (rs2_OF == rd_EX)));

  always_comb begin
    stall_PC   = 1'b0;
    stall_IFOF = 1'b0;
    stall_OFEX = 1'b0;
    stall_EXDM = 1'b0;
    stall_DMWB = 1'b0;
    flush_IFOF = 1'b0;
    flush_OFEX = 1'b0;

    if (mem_stall) begin
      // Whole pipe frozen; branch and load-use are re-evaluated once it moves
      stall_PC   = 1'b1;
      stall_IFOF = 1'b1;
      stall_OFEX = 1'b1;
      stall_EXDM = 1'b1;
      stall_DMWB = 1'b1;
    end else if (branch_taken_EX) begin
      // Consumer of any load-use hazard is being flushed, so no interlock needed
      flush_IFOF = 1'b1;
      flush_OFEX = 1'b1;
    end else if (load_use) begin
      // One bubble; forwarding from DM covers the load afterwards
      stall_PC   = 1'b1;
      stall_IFOF = 1'b1;
      flush_OFEX = 1'b1;
    end
  end

  always_comb begin
    wb_suppress_d = stall_DMWB;
    stall_cnt_d   = stall_cnt_q;
    if (stall_PC && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_suppress_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      wb_suppress_q <= wb_suppress_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign wb_suppress = wb_suppress_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_access_DM, dm_ack, dm_req;
  logic          is_Ld_EX;
  logic [RW-1:0] rd_EX, rs1_OF, rs2_OF;
  logic          use_rs1_OF, use_rs2_OF, branch_taken_EX;
  logic          stall_PC, stall_IFOF, stall_OFEX, stall_EXDM, stall_DMWB;
  logic          flush_IFOF, flush_OFEX, wb_suppress, dm_err, err_clr;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .DM_TIMEOUT(TO),
    .CNT_W     (CW),
    .REG_W     (RW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_access_DM  (mem_access_DM),
    .dm_ack         (dm_ack),
    .dm_req         (dm_req),
    .is_Ld_EX       (is_Ld_EX),
    .rd_EX          (rd_EX),
    .rs1_OF         (rs1_OF),
    .rs2_OF         (rs2_OF),
    .use_rs1_OF     (use_rs1_OF),
    .use_rs2_OF     (use_rs2_OF),
    .branch_taken_EX(branch_taken_EX),
    .stall_PC       (stall_PC),
    .stall_IFOF     (stall_IFOF),
    .stall_OFEX     (stall_OFEX),
    .stall_EXDM     (stall_EXDM),
    .stall_DMWB     (stall_DMWB),
    .flush_IFOF     (flush_IFOF),
    .flush_OFEX     (flush_OFEX),
    .wb_suppress    (wb_suppress),
    .dm_err         (dm_err),
    .err_clr        (err_clr),
    .stall_cnt      (stall_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: age = cycles the current DM access has already been held
  int              m_age;
  logic            m_err, m_prev_hold;
  longint unsigned m_cnt;
  logic [9:0]      exp_v;
  logic [CW-1:0]   exp_cnt;
  logic            e_hold, e_abort, e_spc;

  wire [9:0] obs_v = {dm_req, stall_PC, stall_IFOF, stall_OFEX, stall_EXDM, stall_DMWB,
                      flush_IFOF, flush_OFEX, wb_suppress, dm_err};

  function automatic void model_reset();
    m_age       = 0;
    m_err       = 1'b0;
    m_prev_hold = 1'b0;
    m_cnt       = 0;
  endfunction

  function automatic void model_eval();
    logic pending, hazard, br;
    pending = rst_n && (mem_access_DM || m_age > 0);
    e_hold  = pending && !dm_ack && (m_age < int'(TO) - 1);
    e_abort = pending && !dm_ack && (m_age == int'(TO) - 1);
    hazard  = is_Ld_EX && ((use_rs1_OF && rs1_OF == rd_EX) || (use_rs2_OF && rs2_OF == rd_EX));
    br      = branch_taken_EX;
    e_spc   = e_hold || (!br && hazard);
    exp_v   = {rst_n && mem_access_DM, e_spc, e_spc, e_hold, e_hold, e_hold,
               !e_hold && br, !e_hold && (br || hazard),
               rst_n && m_prev_hold, rst_n && m_err};
    exp_cnt = rst_n ? CW'(m_cnt) : '0;
  endfunction

  // Advance one clock, updating the model with the values the DUT sees at the edge
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_age = e_hold ? m_age + 1 : 0;
      if (e_abort) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (e_spc && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_prev_hold = e_hold;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic ma, input logic ack, input logic ld, input int rd,
                       input int r1, input int r2, input logic u1, input logic u2,
                       input logic br, input logic clr);
    mem_access_DM   = ma;
    dm_ack          = ack;
    is_Ld_EX        = ld;
    rd_EX           = RW'(rd);
    rs1_OF          = RW'(r1);
    rs2_OF          = RW'(r2);
    use_rs1_OF      = u1;
    use_rs2_OF      = u2;
    branch_taken_EX = br;
    err_clr         = clr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    model_eval();
    n_chk++;
    if (obs_v !== 10'b0 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b cnt=%0d, want 0 cnt=0", obs_v, stall_cnt);
    end
    tick();
    rst_n = 1'b1;
    #1;
    model_eval();
    n_chk++;
    if (obs_v !== exp_v || stall_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL reset_release: got %b cnt=%0d, want %b cnt=%0d", obs_v, stall_cnt,
               exp_v, exp_cnt);
    end
  endtask

  // ld in DM, ack on the third request cycle
  task automatic test_mem_wait();
    int n_req, n_stall;
    logic [2:0] wb_seq;
    n_req = 0; n_stall = 0; wb_seq = '0;
    for (int c = 1; c <= 3; c++) begin
      drive(1, c == 3, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      model_eval();
      n_chk++;
      if (obs_v !== exp_v || stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL mem_wait c%0d: got %b cnt=%0d, want %b cnt=%0d", c, obs_v, stall_cnt,
                 exp_v, exp_cnt);
      end
      n_req += int'(dm_req);
      n_stall += int'(stall_PC & stall_IFOF & stall_OFEX & stall_EXDM & stall_DMWB);
      wb_seq[c-1] = wb_suppress;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (n_req != 3 || n_stall != 2 || wb_seq !== 3'b110 || stall_cnt !== 32'd2
        || wb_suppress !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_wait_totals: got req=%0d stall=%0d wb=%b cnt=%0d, want 3 2 110 2",
               n_req, n_stall, wb_seq, stall_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    // {rs1 use, rs2 use, rs2}: rs1 match, rs1 unused, rs2 match
    logic [1:0] uses [3] = '{2'b11, 2'b01, 2'b01};
    int         r2s  [3] = '{1, 1, 3};
    logic       want [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 3, 3, r2s[k], uses[k][1], uses[k][0], 0, 0);
      #1;
      model_eval();
      n_chk++;
      if (obs_v !== exp_v || {stall_PC, stall_IFOF, flush_OFEX, stall_EXDM} !==
          {want[k], want[k], want[k], 1'b0}) begin
        n_fail++;
        $display("FAIL load_use k%0d: got %b, want %b (pc/ifof/fofex=%b exdm=0)", k, obs_v,
                 exp_v, want[k]);
      end
      tick();
      // load has moved on to DM: the bubble is exactly one cycle
      drive(0, 0, 0, 3, 3, r2s[k], uses[k][1], uses[k][0], 0, 0);
      #1;
      model_eval();
      n_chk++;
      if (obs_v !== exp_v || stall_PC !== 1'b0) begin
        n_fail++;
        $display("FAIL load_use_after k%0d: got %b, want %b", k, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    drive(0, 0, 1, 7, 7, 7, 1, 1, 1, 0);
    #1;
    model_eval();
    n_chk++;
    if (obs_v !== exp_v || {flush_IFOF, flush_OFEX, stall_PC, stall_IFOF} !== 4'b1100) begin
      n_fail++;
      $display("FAIL branch_over_load_use: got %b, want %b", obs_v, exp_v);
    end
    tick();
  endtask

  task automatic test_branch_in_wait();
    for (int c = 1; c <= 3; c++) begin
      drive(1, c == 3, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      model_eval();
      n_chk++;
      if (obs_v !== exp_v || {flush_IFOF, flush_OFEX} !== ((c == 3) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL branch_in_wait c%0d: got %b, want %b", c, obs_v, exp_v);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_timeout();
    int n_stall;
    n_stall = 0;
    // err_clr coincides with the abort cycle: the abort must win
    for (int c = 1; c <= int'(TO); c++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, c == int'(TO));
      #1;
      model_eval();
      n_chk++;
      if (obs_v !== exp_v || stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL timeout c%0d: got %b cnt=%0d, want %b cnt=%0d", c, obs_v, stall_cnt,
                 exp_v, exp_cnt);
      end
      n_stall += int'(stall_DMWB);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (n_stall != 15 || dm_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_release: got stalls=%0d err=%b, want 15 1", n_stall, dm_err);
    end
    tick();
    tick();
    n_chk++;
    if (dm_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, want 1", dm_err);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (dm_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b, want 0", dm_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({dm_req, stall_PC, stall_IFOF, stall_OFEX, stall_EXDM, stall_DMWB} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got req/stalls=%b, want 000000",
               {dm_req, stall_PC, stall_IFOF, stall_OFEX, stall_EXDM, stall_DMWB});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    model_eval();
    n_chk++;
    if (obs_v !== exp_v || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL after_reset: got %b cnt=%0d, want %b cnt=0", obs_v, stall_cnt, exp_v);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_chk++;
      if (stall_PC !== 1'b0 || stall_DMWB !== 1'b0 || dm_req !== 1'b1 || stall_cnt !== '0)
      begin
        n_fail++;
        $display("FAIL back_to_back c%0d: got spc=%b sdmwb=%b req=%b cnt=%0d, want 0 0 1 0",
                 c, stall_PC, stall_DMWB, dm_req, stall_cnt);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive((m_age > 0) || ($urandom_range(2) == 0), $urandom_range(3) == 0,
            $urandom_range(1), $urandom_range(3), $urandom_range(3), $urandom_range(3),
            $urandom_range(1), $urandom_range(1), $urandom_range(4) == 0,
            $urandom_range(15) == 0);
      #1;
      model_eval();
      n_chk++;
      if (obs_v !== exp_v || stall_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL random c%0d: got %b cnt=%0d, want %b cnt=%0d", c, obs_v, stall_cnt,
                 exp_v, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mem_wait();
    test_load_use();
    test_branch();
    test_branch_in_wait();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
